// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : TAP state codes and instruction opcodes shared by the TAP
//                controller and its FSM.
//  Revision    : 1.0
// ============================================================================
package jtag_pkg;

    localparam logic [3:0] c_TLR      = 4'hF;
    localparam logic [3:0] c_RTI      = 4'hC;
    localparam logic [3:0] c_SEL_DR   = 4'h7;
    localparam logic [3:0] c_CAP_DR   = 4'h6;
    localparam logic [3:0] c_SH_DR    = 4'h2;
    localparam logic [3:0] c_EX1_DR   = 4'h1;
    localparam logic [3:0] c_PAUSE_DR = 4'h3;
    localparam logic [3:0] c_EX2_DR   = 4'h0;
    localparam logic [3:0] c_UPD_DR   = 4'h5;
    localparam logic [3:0] c_SEL_IR   = 4'h4;
    localparam logic [3:0] c_CAP_IR   = 4'hE;
    localparam logic [3:0] c_SH_IR    = 4'hA;
    localparam logic [3:0] c_EX1_IR   = 4'h9;
    localparam logic [3:0] c_PAUSE_IR = 4'hB;
    localparam logic [3:0] c_EX2_IR   = 4'h8;
    localparam logic [3:0] c_UPD_IR   = 4'hD;

    localparam logic [1:0] c_INSTR_SCAN   = 2'b01;
    localparam logic [1:0] c_INSTR_BYPASS = 2'b11;

endpackage
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tap_fsm
//  Description : 16-state TAP state register with tms-driven next-state logic.
//  Revision    : 1.0
// ============================================================================
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next;

    always_comb begin
        w_next = c_TLR;
        case (r_state)
            c_TLR:      w_next = tms ? c_TLR    : c_RTI;
            c_RTI:      w_next = tms ? c_SEL_DR : c_RTI;
            c_SEL_DR:   w_next = tms ? c_SEL_IR : c_CAP_DR;
            c_CAP_DR:   w_next = tms ? c_EX1_DR : c_SH_DR;
            c_SH_DR:    w_next = tms ? c_EX1_DR : c_SH_DR;
            c_EX1_DR:   w_next = tms ? c_UPD_DR : c_PAUSE_DR;
            c_PAUSE_DR: w_next = tms ? c_EX2_DR : c_PAUSE_DR;
            c_EX2_DR:   w_next = tms ? c_UPD_DR : c_SH_DR;
            c_UPD_DR:   w_next = tms ? c_SEL_DR : c_RTI;
            c_SEL_IR:   w_next = tms ? c_TLR    : c_CAP_IR;
            c_CAP_IR:   w_next = tms ? c_EX1_IR : c_SH_IR;
            c_SH_IR:    w_next = tms ? c_EX1_IR : c_SH_IR;
            c_EX1_IR:   w_next = tms ? c_UPD_IR : c_PAUSE_IR;
            c_PAUSE_IR: w_next = tms ? c_EX2_IR : c_PAUSE_IR;
            c_EX2_IR:   w_next = tms ? c_UPD_IR : c_SH_IR;
            c_UPD_IR:   w_next = tms ? c_SEL_DR : c_RTI;
            default:    w_next = c_TLR;
        endcase
    end

    // Reset wins over tms, so a shift in progress is abandoned without an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tap_controller
//  Description : TAP controller: strobe decode, bypass register and tdo mux.
//  Revision    : 1.0
// ============================================================================
module tap_controller
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = 2,
    parameter logic [IR_WIDTH-1:0]   INSTR_SCAN   = IR_WIDTH'(c_INSTR_SCAN),
    parameter logic [IR_WIDTH-1:0]   INSTR_BYPASS = IR_WIDTH'(c_INSTR_BYPASS)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                tms,
    input  logic                tdi,
    input  logic [IR_WIDTH-1:0] instruction,
    input  logic                ir_tdo,
    input  logic                scan_tdo,
    output logic                ir_shift,
    output logic                ir_capture,
    output logic                ir_update,
    output logic                dr_shift,
    output logic                dr_capture,
    output logic                dr_update,
    output logic                scan_reset,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          state
);

    logic r_bypass;
    logic w_sel_scan;
    logic w_sel_bypass;

    tap_fsm u_fsm (
        .clk   (clk),
        .reset (reset),
        .tms   (tms),
        .state (state)
    );

    // Only the SCAN opcode reaches scan_block; BYPASS and every unknown opcode use the bypass bit.
    assign w_sel_scan   = (instruction == INSTR_SCAN);
    assign w_sel_bypass = !w_sel_scan || (instruction == INSTR_BYPASS);

    assign ir_shift   = (state == c_SH_IR);
    assign ir_capture = (state == c_CAP_IR);
    assign ir_update  = (state == c_UPD_IR);
    assign dr_shift   = (state == c_SH_DR)  && w_sel_scan;
    assign dr_capture = (state == c_CAP_DR) && w_sel_scan;
    assign dr_update  = (state == c_UPD_DR) && w_sel_scan;
    assign scan_reset = (state == c_TLR);
    assign tdo_en     = (state == c_SH_IR) || (state == c_SH_DR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass) begin
            if (state == c_CAP_DR) begin
                r_bypass <= 1'b0;
            end else if (state == c_SH_DR) begin
                r_bypass <= tdi;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state == c_SH_IR) begin
            tdo = ir_tdo;
        end else if (state == c_SH_DR) begin
            tdo = w_sel_scan ? scan_tdo : r_bypass;
        end
    end

endmodule
`default_nettype wire
